// File: rtl/prog_timer_pkg.sv
// rtl/prog_timer_pkg.sv - register map, CTRL bits, store size codes, FSM encoding and lane merge helper
package prog_timer_pkg;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_LOAD   = 3'd1;
    localparam logic [2:0] OFF_COUNT  = 3'd2;
    localparam logic [2:0] OFF_PRESC  = 3'd3;
    localparam logic [2:0] OFF_STATUS = 3'd4;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_RELOAD = 1;
    localparam int CTRL_IE     = 2;

    localparam logic [2:0] MEMC_BYTE = 3'd0;
    localparam logic [2:0] MEMC_HALF = 3'd1;
    localparam logic [2:0] MEMC_WORD = 3'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Merge right-aligned store data into the addressed lane of an existing word.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] di,
                                               input logic [2:0]  memc,
                                               input logic [1:0]  lane);
        logic [31:0] r;
        r = old_val;
        case (memc)
            MEMC_BYTE: begin
                case (lane)
                    2'd0:    r[7:0]   = di[7:0];
                    2'd1:    r[15:8]  = di[7:0];
                    2'd2:    r[23:16] = di[7:0];
                    default: r[31:24] = di[7:0];
                endcase
            end
            MEMC_HALF: begin
                if (lane[1]) r[31:16] = di[15:0];
                else         r[15:0]  = di[15:0];
            end
            MEMC_WORD: r = di;
            default:   r = old_val;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/prog_timer_prescaler.sv
// rtl/prog_timer_prescaler.sv - 16-bit prescale divider producing a one-cycle tick on wrap
module prog_timer_prescaler
    import prog_timer_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic [15:0] presc_i,
    input  logic        presc_wr_i,
    input  logic [15:0] presc_new_i,
    output logic        tick_o
);

    logic [15:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == presc_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)       cnt_d = '0;
        else if (tick_o) cnt_d = '0;
        else if (en_i)   cnt_d = cnt_q + 16'd1;
        // A shrinking divisor must not leave the phase beyond the new wrap point.
        if (presc_wr_i && (cnt_d > presc_new_i)) cnt_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/prog_timer.sv
// rtl/prog_timer.sv - bus-mapped prescaled down-counter timer; PROG_TIMER_IRQ_EN adds CTRL.IE and irq
module prog_timer
    import prog_timer_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        wmem,
    input  logic [2:0]  memc,
    input  logic [31:0] A_TIMER,
    input  logic [31:0] Di,
    output logic [31:0] Do_Timer
`ifdef PROG_TIMER_IRQ_EN
    ,
    output logic        irq
`endif
);

    state_e      state_q, state_d;
    logic        reload_q, reload_d;
    logic [31:0] load_q, load_d;
    logic [31:0] count_q, count_d;
    logic [15:0] presc_q, presc_d;
    logic        exp_q, exp_d;
    logic        ie;

`ifdef PROG_TIMER_IRQ_EN
    logic ie_q, ie_d;
    assign ie  = ie_q;
    assign irq = exp_q & ie_q;
`else
    assign ie = 1'b0;
`endif

    logic [2:0]  off;
    logic        mapped, wr_en, tick, expiry, status_clr, presc_clr;
    logic        sel_ctrl, sel_load, sel_count, sel_presc, sel_status;
    logic [31:0] wr_val;
    logic        unused_addr;

    assign off         = A_TIMER[4:2];
    assign mapped      = (A_TIMER[27:5] == 23'd0);
    assign unused_addr = ^A_TIMER[31:28];
    assign wr_en       = wmem && mapped && (memc <= MEMC_WORD);
    assign sel_ctrl    = wr_en && (off == OFF_CTRL);
    assign sel_load    = wr_en && (off == OFF_LOAD);
    assign sel_count   = wr_en && (off == OFF_COUNT);
    assign sel_presc   = wr_en && (off == OFF_PRESC);
    assign sel_status  = wr_en && (off == OFF_STATUS);

    always_comb begin
        Do_Timer = '0;
        if (mapped) begin
            case (off)
                OFF_CTRL:   Do_Timer = {29'd0, ie, reload_q, state_q == ST_RUN};
                OFF_LOAD:   Do_Timer = load_q;
                OFF_COUNT:  Do_Timer = count_q;
                OFF_PRESC:  Do_Timer = {16'd0, presc_q};
                OFF_STATUS: Do_Timer = {31'd0, exp_q};
                default:    Do_Timer = '0;
            endcase
        end
    end

    // Stores target the same register the read mux selects, so merge over its current value.
    assign wr_val = lane_merge(Do_Timer, Di, memc, A_TIMER[1:0]);

    // EXP is write-1-to-clear: only a store whose lanes cover bit 0 can clear it.
    assign status_clr = sel_status && Di[0] &&
                        ((memc == MEMC_WORD) ||
                         ((memc == MEMC_HALF) && !A_TIMER[1]) ||
                         ((memc == MEMC_BYTE) && (A_TIMER[1:0] == 2'd0)));

    assign expiry    = tick && (count_q == 32'd0);
    assign presc_clr = (sel_ctrl && wr_val[CTRL_EN] && (state_q == ST_IDLE)) || sel_count;

    always_comb begin
        state_d  = state_q;
        reload_d = reload_q;
        load_d   = load_q;
        count_d  = count_q;
        presc_d  = presc_q;
        exp_d    = exp_q;
`ifdef PROG_TIMER_IRQ_EN
        ie_d     = ie_q;
`endif
        if (tick) begin
            if (count_q != 32'd0) count_d = count_q - 32'd1;
            else if (reload_q)    count_d = load_q;
        end
        if (expiry && !reload_q) state_d = ST_IDLE;
        // An explicit CTRL store overrides a same-cycle one-shot disable.
        if (sel_ctrl) begin
            state_d  = wr_val[CTRL_EN] ? ST_RUN : ST_IDLE;
            reload_d = wr_val[CTRL_RELOAD];
`ifdef PROG_TIMER_IRQ_EN
            ie_d     = wr_val[CTRL_IE];
`endif
        end
        if (sel_load)   load_d  = wr_val;
        if (sel_count)  count_d = wr_val;
        if (sel_presc)  presc_d = wr_val[15:0];
        if (status_clr) exp_d   = 1'b0;
        if (expiry)     exp_d   = 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            reload_q <= 1'b0;
            load_q   <= '0;
            count_q  <= '0;
            presc_q  <= '0;
            exp_q    <= 1'b0;
`ifdef PROG_TIMER_IRQ_EN
            ie_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            load_q   <= load_d;
            count_q  <= count_d;
            presc_q  <= presc_d;
            exp_q    <= exp_d;
`ifdef PROG_TIMER_IRQ_EN
            ie_q     <= ie_d;
`endif
        end
    end

    prog_timer_prescaler u_presc (
        .clk_i       (CLK),
        .rst_ni      (RESET),
        .en_i        (state_q == ST_RUN),
        .clr_i       (presc_clr),
        .presc_i     (presc_q),
        .presc_wr_i  (sel_presc),
        .presc_new_i (wr_val[15:0]),
        .tick_o      (tick)
    );

endmodule

// File: tb/tb_prog_timer.sv
// tb/tb_prog_timer.sv - scoreboard bench for prog_timer with directed and randomized bus traffic
module tb_prog_timer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        wmem = 1'b0;
    logic [2:0]  memc = 3'd0;
    logic [31:0] A_TIMER = 32'd0;
    logic [31:0] Di = 32'd0;
    logic [31:0] Do_Timer;
`ifdef PROG_TIMER_IRQ_EN
    logic        irq;
`endif

    always #5 CLK = ~CLK;

    prog_timer dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .wmem     (wmem),
        .memc     (memc),
        .A_TIMER  (A_TIMER),
        .Di       (Di),
        .Do_Timer (Do_Timer)
`ifdef PROG_TIMER_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rd_q[$];
    logic [31:0] addr_q[$];
    logic        exp_irq_q[$];
    bit          chk_valid = 1'b0;
    bit          rst_drive = 1'b0;

    bit          m_en, m_reload, m_ie, m_exp;
    logic [31:0] m_load, m_count;
    logic [15:0] m_presc;
    int          m_pc;

    task automatic m_reset();
        m_en = 0; m_reload = 0; m_ie = 0; m_exp = 0;
        m_load = 0; m_count = 0; m_presc = 0; m_pc = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[27:5] != 23'd0) return 32'd0;
        case (a[4:2])
            3'd0:    return {29'd0, m_ie, m_reload, m_en};
            3'd1:    return m_load;
            3'd2:    return m_count;
            3'd3:    return {16'd0, m_presc};
            3'd4:    return {31'd0, m_exp};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] merged(input logic [31:0] old_val, input logic [31:0] di,
                                           input logic [2:0] mc, input logic [31:0] a);
        logic [31:0] mask, data;
        int sh;
        mask = 32'd0; data = 32'd0;
        if (mc == 3'd0) begin
            sh = 8 * int'(a[1:0]);
            mask = 32'hFF << sh; data = {24'd0, di[7:0]} << sh;
        end else if (mc == 3'd1) begin
            sh = 16 * int'(a[1]);
            mask = 32'hFFFF << sh; data = {16'd0, di[15:0]} << sh;
        end else if (mc == 3'd2) begin
            mask = 32'hFFFF_FFFF; data = di;
        end
        return (old_val & ~mask) | (data & mask);
    endfunction

    // One clock edge of the timer's rules applied to the model.
    task automatic m_step(input bit w, input logic [2:0] mc, input logic [31:0] a, input logic [31:0] di);
        bit          tick, expired, old_en;
        logic [31:0] old_ctrl, old_count, nv;
        old_en    = m_en;
        old_ctrl  = m_read(32'h0);
        old_count = m_count;
        tick      = m_en && (m_pc == int'(m_presc));
        expired   = tick && (m_count == 0);
        if (tick) m_pc = 0;
        else if (m_en) m_pc = m_pc + 1;
        if (tick) begin
            if (m_count != 0) m_count = m_count - 1;
            else if (m_reload) m_count = m_load;
            else m_en = 0;
        end
        if (w && a[27:5] == 23'd0 && mc <= 3'd2) begin
            case (a[4:2])
                3'd0: begin
                    nv = merged(old_ctrl, di, mc, a);
                    m_en = nv[0]; m_reload = nv[1];
`ifdef PROG_TIMER_IRQ_EN
                    m_ie = nv[2];
`endif
                    if (!old_en && nv[0]) m_pc = 0;
                end
                3'd1: m_load = merged(m_load, di, mc, a);
                3'd2: begin m_count = merged(old_count, di, mc, a); m_pc = 0; end
                3'd3: begin
                    nv = merged({16'd0, m_presc}, di, mc, a);
                    m_presc = nv[15:0];
                    if (m_pc > int'(m_presc)) m_pc = 0;
                end
                3'd4: begin
                    nv = merged(32'd0, di, mc, a);
                    if (nv[0]) m_exp = 0;
                end
                default: ;
            endcase
        end
        if (expired) m_exp = 1;
    endtask

    task automatic cyc(input bit w, input logic [2:0] mc, input logic [31:0] a, input logic [31:0] di);
        @(posedge CLK);
        #1;
        if (RESET && !rst_drive) m_reset();
        RESET = rst_drive;
        wmem = w; memc = mc; A_TIMER = a; Di = di;
        exp_rd_q.push_back(m_read(a));
        addr_q.push_back(a);
        exp_irq_q.push_back(m_exp & m_ie);
        chk_valid = 1'b1;
        if (RESET) m_step(w, mc, a, di);
    endtask

    always @(negedge CLK) begin
        if (chk_valid) begin
            checks++;
            if (exp_rd_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty t=%0t", $time);
            end else begin
                logic [31:0] e, a;
                logic        ei;
                e = exp_rd_q.pop_front();
                a = addr_q.pop_front();
                ei = exp_irq_q.pop_front();
                if (Do_Timer !== e) begin
                    errors++;
                    $display("FAIL do_timer addr=%h got=%h exp=%h t=%0t", a, Do_Timer, e, $time);
                end
`ifdef PROG_TIMER_IRQ_EN
                checks++;
                if (irq !== ei) begin
                    errors++;
                    $display("FAIL irq got=%b exp=%b t=%0t", irq, ei, $time);
                end
`else
                if (ei !== 1'b0) ;
`endif
            end
        end
    end

    initial begin
        m_reset();
        rst_drive = 1'b0;
        repeat (2) cyc(1, 3'd2, 32'h8, 32'h55);
        rst_drive = 1'b1;
        for (int i = 0; i < 6; i++) cyc(0, 3'd2, 32'(i * 4), 32'd0);

        // auto-reload: LOAD=3, PRESC=1, EN|RELOAD|IE
        cyc(1, 3'd2, 32'h4, 32'd3);
        cyc(1, 3'd2, 32'hC, 32'd1);
        cyc(1, 3'd2, 32'h0, 32'h7);
        for (int i = 0; i < 24; i++) cyc(0, 3'd2, (i % 3 == 2) ? 32'h10 : 32'h8, 32'd0);

        // one-shot: COUNT=2, PRESC=0, EN only
        cyc(1, 3'd2, 32'h0, 32'h0);
        cyc(1, 3'd2, 32'h10, 32'h1);
        cyc(1, 3'd2, 32'hC, 32'h0);
        cyc(1, 3'd2, 32'h8, 32'h2);
        cyc(1, 3'd2, 32'h0, 32'h1);
        for (int i = 0; i < 5; i++) cyc(0, 3'd2, 32'h10, 32'd0);
        cyc(0, 3'd2, 32'h0, 32'd0);
        cyc(0, 3'd2, 32'h8, 32'd0);

        // sub-word stores into LOAD
        cyc(1, 3'd2, 32'h4, 32'h0);
        cyc(1, 3'd0, 32'h5, 32'hAB);
        cyc(1, 3'd1, 32'h6, 32'h1234);
        cyc(0, 3'd2, 32'h4, 32'd0);

        // STATUS clear racing an auto-reload expiry, then a quiet clear
        cyc(1, 3'd2, 32'h10, 32'h1);
        cyc(1, 3'd2, 32'h4, 32'h1);
        cyc(1, 3'd2, 32'h8, 32'h0);
        cyc(1, 3'd2, 32'h0, 32'h7);
        cyc(1, 3'd2, 32'h10, 32'h1);
        cyc(1, 3'd2, 32'h0, 32'h6);
        cyc(0, 3'd2, 32'h10, 32'h0);
        cyc(1, 3'd2, 32'h10, 32'h1);
        cyc(0, 3'd2, 32'h10, 32'h0);

        // reset mid-count
        cyc(1, 3'd2, 32'h4, 32'h0);
        cyc(1, 3'd2, 32'h8, 32'd100);
        cyc(1, 3'd2, 32'h0, 32'h1);
        repeat (3) cyc(0, 3'd2, 32'h8, 32'd0);
        rst_drive = 1'b0;
        cyc(0, 3'd2, 32'h8, 32'd0);
        cyc(1, 3'd2, 32'h0, 32'h7);
        cyc(0, 3'd2, 32'h10, 32'd0);
        rst_drive = 1'b1;
        for (int i = 0; i < 6; i++) cyc(0, 3'd2, 32'(4 * (i % 5)), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            int          idx;
            logic [31:0] a, d;
            logic [2:0]  mc;
            bit          w;
            idx = $urandom_range(0, 6);
            a   = (idx < 6) ? 32'(idx * 4) : (32'h20 << $urandom_range(0, 22));
            a   = a | 32'($urandom_range(0, 3));
            mc  = ($urandom_range(0, 9) < 7) ? 3'd2 : 3'($urandom_range(0, 3));
            d   = ($urandom_range(0, 19) == 0) ? $urandom() : 32'($urandom_range(0, 7));
            w   = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 599) == 0) rst_drive = 1'b0;
            else if (!rst_drive && $urandom_range(0, 1) == 1) rst_drive = 1'b1;
            cyc(w, mc, a, d);
        end

        @(negedge CLK);
        #1;
        chk_valid = 1'b0;
        checks++;
        if (exp_rd_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_rd_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_timer.md
# prog_timer

Memory-mapped programmable down-counter timer that sits as a responder on the system bus, behind the timer address window (A[31:28] = 4'd2). The bus supplies a local address with the window bits stripped, the store strobe and size code, and write data. The block returns read data combinationally in the same cycle. It implements a prescaled down-counter with one-shot and auto-reload modes, a sticky expiry flag, and an optional interrupt line.

## Interface
- No parameters; register map and widths are fixed constants in the package.
- CLK  input  1  system clock, all state updates on rising edge
- RESET  input  1  asynchronous, active-low reset
- wmem  input  1  write strobe, already qualified by the bus chip-select for this window
- memc  input  3  store size: 0 = byte, 1 = halfword, 2 = word, others = no write
- A_TIMER  input  32  local byte address, bits [31:28] always 0
- Di  input  32  write data, right-aligned (byte in [7:0], half in [15:0])
- Do_Timer  output  32  read data for A_TIMER, combinational
- irq  output  1  level interrupt request (present only with PROG_TIMER_IRQ_EN)

## Operation
- Register map, decoded on A_TIMER[4:2]; any nonzero bit in A_TIMER[27:5] is unmapped:
  - 0x00 CTRL: bit0 EN, bit1 RELOAD, bit2 IE; other bits read 0.
  - 0x04 LOAD: 32-bit reload value.
  - 0x08 COUNT: current count. A write loads the counter directly.
  - 0x0C PRESC: bits [15:0] prescale divisor minus 1; upper bits read 0.
  - 0x10 STATUS: bit0 EXP, sticky. Writing 1 clears it; writing 0 has no effect.
- Unmapped offsets read 32'h0; writes to them are ignored.
- Sub-word writes:
  - memc=0 merges Di[7:0] into the byte lane A_TIMER[1:0].
  - memc=1 merges Di[15:0] into the half lane A_TIMER[1]; A_TIMER[0] is ignored.
  - memc=2 writes the full word.
- States:
  - IDLE (EN=0): counter and prescaler hold.
  - RUN (EN=1): the prescaler counts 0..PRESC and issues a one-cycle tick when it wraps from PRESC to 0.
- On each tick in RUN:
  - If COUNT != 0, COUNT decrements.
  - If COUNT == 0, an expiry occurs and EXP is set.
  - On expiry with RELOAD=1: COUNT <= LOAD, stay in RUN.
  - On expiry with RELOAD=0: EN clears, COUNT stays 0, go to IDLE.
- Expiry period in auto-reload mode is (LOAD+1)*(PRESC+1) cycles.
- A CTRL write that takes EN from 0 to 1 clears the prescaler. COUNT is not touched.
- A CTRL write that clears EN takes effect at once; no further ticks occur.

## Timing
- Reset: every register, EN, EXP and the prescaler are 0, and the state is IDLE. Do_Timer reflects those zeros; irq = 0.
- Reads: zero latency. Do_Timer is valid in the same cycle A_TIMER is presented, and shows pre-edge register values.
- Writes: committed on the rising edge where wmem=1. They are visible on reads starting the next cycle.
- First tick after an EN rise arrives PRESC+1 cycles after the enabling edge.
- Conflicting events in the same cycle:
  - COUNT write vs. tick: the write wins and the prescaler clears.
  - PRESC write vs. tick: the new PRESC is used from the next cycle; the current prescaler value is kept, and clamped to 0 if it exceeds the new PRESC.
  - STATUS clear vs. expiry: the set wins, so EXP stays 1.
  - CTRL write clearing EN vs. one-shot expiry: EXP is still set.
- Wrap-around: LOAD=0 with RELOAD=1 expires on every tick. COUNT never wraps below 0.
- RESET asserted mid-count: everything clears immediately and asynchronously. Operation resumes from the reset state on the first edge after deassertion.

## Configuration
- PROG_TIMER_IRQ_EN defined:
  - irq port exists.
  - irq = EXP & IE, with a combinational path from registered bits. It is high from the edge after the expiry edge until the EXP clear edge.
- PROG_TIMER_IRQ_EN undefined:
  - irq port is omitted.
  - CTRL bit2 is not stored and reads 0.
  - EXP still operates and is polled through STATUS.

## Structure
- Package prog_timer_pkg holds:
  - register offsets (CTRL/LOAD/COUNT/PRESC/STATUS)
  - CTRL bit indices
  - memc size codes
  - the IDLE/RUN state encoding
- Sub-module prog_timer_prescaler holds the 16-bit divider counter. It takes the enable, clear and PRESC inputs and produces the tick output.
- Register file, byte-lane merge and read mux stay in prog_timer.

## Test plan
- Reset then read all five offsets, plus offset 0x14 -> all read 32'h0; irq=0.
- Write LOAD=3, PRESC=1, then CTRL=0x7 -> EXP sets and irq rises every 8 cycles; COUNT reads 3,3,2,2,1,1,0,0 repeating.
- One-shot: COUNT=2, PRESC=0, CTRL=0x1 -> EXP sets 3 cycles after enable; CTRL reads 0; COUNT holds 0.
- Byte write 0xAB at 0x05, then half write 0x1234 at 0x06, over LOAD=0 -> LOAD reads 32'h1234AB00.
- Write-1 to STATUS in the same cycle as an auto-reload expiry -> EXP stays 1. A later clear with no expiry -> EXP=0 and irq=0.
- Assert RESET mid-count with COUNT=100 -> COUNT, CTRL and EXP read 0 while RESET is held and after release; no ticks occur.
